regbank_ctx: RTL and testbench

REGBANK_CTX -- requirements
Module: regbank_ctx

---
 rtl/regbank_ctx_pkg.sv | 17 +
 rtl/regbank_ctx_seq.sv | 65 ++++++
 rtl/regbank_ctx.sv | 122 ++++++++++++
 tb/tb_regbank_ctx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_ctx_pkg.sv
// Shared definitions for the banked register file and its context sequencer.
// Sequencer state encoding, architectural register indices and reset PC.
package regbank_ctx_pkg;

    typedef logic [1:0] ctx_state_t;

    localparam ctx_state_t ST_IDLE    = 2'd0;
    localparam ctx_state_t ST_SAVE    = 2'd1;
    localparam ctx_state_t ST_RESTORE = 2'd2;
    localparam ctx_state_t ST_DONE    = 2'd3;

    localparam logic [2:0] SP_IDX = 3'd6;
    localparam logic [2:0] PC_IDX = 3'd7;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'o100000;

endpackage

// File: rtl/regbank_ctx_seq.sv
// Context save/restore sequencer: walks R0..R(NSAVE-1) over a valid/ready stream.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no transfer; ctx_start launches save or restore
// ST_SAVE    | presenting R[cnt] on the save stream, waiting for sv_ready
// ST_RESTORE | accepting rs_data into R[cnt], waiting for rs_valid
// ST_DONE    | single ce cycle with ctx_done=1, then back to idle
module regbank_ctx_seq
    import regbank_ctx_pkg::*;
#(
    parameter int NSAVE = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       ctx_start,
    input  logic       ctx_restore,
    input  logic       sv_ready,
    input  logic       rs_valid,
    output logic       ctx_busy,
    output logic       ctx_done,
    output logic       sv_valid,
    output logic       rs_ready,
    output logic       rst_we,
    output logic [2:0] cnt
);

    localparam logic [2:0] LAST = 3'(NSAVE - 1);

    ctx_state_t state;
    logic       xfer;

    assign sv_valid = (state == ST_SAVE);
    assign rs_ready = (state == ST_RESTORE);
    assign ctx_done = (state == ST_DONE);
    assign ctx_busy = (state != ST_IDLE);
    assign xfer     = (sv_valid & sv_ready) | (rs_ready & rs_valid);
    assign rst_we   = ce & rs_ready & rs_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (ce) begin
            case (state)
                ST_IDLE: begin
                    if (ctx_start) begin
                        cnt   <= '0;
                        state <= ctx_restore ? ST_RESTORE : ST_SAVE;
                    end
                end
                ST_SAVE, ST_RESTORE: begin
                    if (xfer) begin
                        if (cnt == LAST) state <= ST_DONE;
                        else             cnt   <= cnt + 3'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regbank_ctx.sv
// Register bank R0..R5, per-mode banked SP and PC with two write ports and context streaming.
// Optional REGBANK_RTEST_EN exposes the full register state on rtest.
module regbank_ctx
    import regbank_ctx_pkg::*;
#(
    parameter int            W        = 16,
    parameter int            NMODES   = 2,
    parameter int            NSAVE    = 6,
    parameter logic [W-1:0]  RESET_PC = W'(DEFAULT_RESET_PC),
    localparam int           MW       = (NMODES > 1) ? $clog2(NMODES) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [MW-1:0] mode,
    output logic [W-1:0]  pc,
    output logic [W-1:0]  sp,
    input  logic [2:0]    rs_a,
    input  logic [2:0]    rs_b,
    output logic [W-1:0]  rd_a,
    output logic [W-1:0]  rd_b,
    input  logic          we_a,
    input  logic [2:0]    wa_a,
    input  logic [W-1:0]  wd_a,
    input  logic          we_b,
    input  logic [2:0]    wa_b,
    input  logic [W-1:0]  wd_b,
    input  logic          pc_we,
    input  logic [W-1:0]  pc_wd,
    input  logic          ctx_start,
    input  logic          ctx_restore,
    output logic          ctx_busy,
    output logic          ctx_done,
    output logic          sv_valid,
    input  logic          sv_ready,
    output logic [W-1:0]  sv_data,
    output logic [2:0]    sv_idx,
    input  logic          rs_valid,
    output logic          rs_ready,
    input  logic [W-1:0]  rs_data
`ifdef REGBANK_RTEST_EN
    ,
    output logic [(8+NMODES)*W-1:0] rtest
`endif
);

    logic [W-1:0]  r    [6];
    logic [W-1:0]  sp_q [NMODES];
    logic [W-1:0]  pc_q;
    logic [W-1:0]  view [8];
    logic [MW-1:0] msel;
    logic [2:0]    cnt;
    logic          rst_we;
    logic          a_ok;
    logic          b_ok;

    regbank_ctx_seq #(.NSAVE(NSAVE)) u_seq (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .ctx_start   (ctx_start),
        .ctx_restore (ctx_restore),
        .sv_ready    (sv_ready),
        .rs_valid    (rs_valid),
        .ctx_busy    (ctx_busy),
        .ctx_done    (ctx_done),
        .sv_valid    (sv_valid),
        .rs_ready    (rs_ready),
        .rst_we      (rst_we),
        .cnt         (cnt)
    );

    // Out-of-range modes fall back to bank 0.
    assign msel = (int'(mode) < NMODES) ? mode : '0;

    always_comb begin
        for (int i = 0; i < 6; i++) view[i] = r[i];
        view[6] = sp_q[msel];
        view[7] = pc_q;
    end

    assign rd_a    = view[rs_a];
    assign rd_b    = view[rs_b];
    assign pc      = pc_q;
    assign sp      = sp_q[msel];
    assign sv_idx  = cnt;
    assign sv_data = view[cnt];

    // The context registers belong to the sequencer while a transfer is in flight.
    assign a_ok = we_a & ~(ctx_busy & (int'(wa_a) < NSAVE));
    assign b_ok = we_b & ~(ctx_busy & (int'(wa_b) < NSAVE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 6; i++)      r[i]    <= '0;
            for (int m = 0; m < NMODES; m++) sp_q[m] <= '0;
            pc_q <= RESET_PC;
        end else if (ce) begin
            for (int i = 0; i < 6; i++) begin
                if (rst_we && cnt == 3'(i))       r[i] <= rs_data;
                else if (a_ok && wa_a == 3'(i))   r[i] <= wd_a;
                else if (b_ok && wa_b == 3'(i))   r[i] <= wd_b;
            end
            if (a_ok && wa_a == SP_IDX)      sp_q[msel] <= wd_a;
            else if (b_ok && wa_b == SP_IDX) sp_q[msel] <= wd_b;
            if (pc_we)                       pc_q <= pc_wd;
            else if (a_ok && wa_a == PC_IDX) pc_q <= wd_a;
            else if (b_ok && wa_b == PC_IDX) pc_q <= wd_b;
        end
    end

`ifdef REGBANK_RTEST_EN
    // Word 6 carries pc; SP banks follow; the top word is padding.
    always_comb begin
        rtest = '0;
        for (int i = 0; i < 6; i++)      rtest[i*W +: W]     = r[i];
        rtest[6*W +: W] = pc_q;
        for (int m = 0; m < NMODES; m++) rtest[(7+m)*W +: W] = sp_q[m];
    end
`endif

endmodule

// File: tb/tb_regbank_ctx.sv
// Self-checking bench for regbank_ctx: reference model of register/stream behaviour plus directed checks.
module tb_regbank_ctx;

    localparam int W      = 16;
    localparam int NMODES = 2;
    localparam int NSAVE  = 6;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         ce = 1'b1;
    logic [0:0]   mode = '0;
    logic [W-1:0] pc, sp, rd_a, rd_b, sv_data;
    logic [2:0]   rs_a = '0, rs_b = '0, wa_a = '0, wa_b = '0, sv_idx;
    logic         we_a = 0, we_b = 0, pc_we = 0;
    logic [W-1:0] wd_a = '0, wd_b = '0, pc_wd = '0, rs_data = '0;
    logic         ctx_start = 0, ctx_restore = 0, ctx_busy, ctx_done;
    logic         sv_valid, sv_ready = 0, rs_valid = 0, rs_ready;

    always #5 clk = ~clk;

    regbank_ctx #(.W(W), .NMODES(NMODES), .NSAVE(NSAVE)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode), .pc(pc), .sp(sp),
        .rs_a(rs_a), .rs_b(rs_b), .rd_a(rd_a), .rd_b(rd_b),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .pc_we(pc_we), .pc_wd(pc_wd), .ctx_start(ctx_start), .ctx_restore(ctx_restore),
        .ctx_busy(ctx_busy), .ctx_done(ctx_done), .sv_valid(sv_valid), .sv_ready(sv_ready),
        .sv_data(sv_data), .sv_idx(sv_idx), .rs_valid(rs_valid), .rs_ready(rs_ready),
        .rs_data(rs_data)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus transfer progress.
    logic [W-1:0] m_r [6];
    logic [W-1:0] m_sp [NMODES];
    logic [W-1:0] m_pc;
    int m_kind;   // 0 none, 1 saving, 2 restoring, 3 finishing
    int m_pos;

    function automatic int msel_f();
        return (int'(mode) < NMODES) ? int'(mode) : 0;
    endfunction

    function automatic logic [W-1:0] m_read(input logic [2:0] idx);
        if (idx < 3'd6) return m_r[idx];
        if (idx == 3'd6) return m_sp[msel_f()];
        return m_pc;
    endfunction

    task automatic m_write(input logic [2:0] idx, input logic [W-1:0] d, input bit busy, input int s);
        if (idx < 3'd6) begin
            if (!(busy && int'(idx) < NSAVE)) m_r[idx] = d;
        end else if (idx == 3'd6) m_sp[s] = d;
        else m_pc = d;
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        bit busy;
        int s;
        if (!reset_n) begin
            foreach (m_r[i]) m_r[i] = '0;
            foreach (m_sp[i]) m_sp[i] = '0;
            m_pc = 16'o100000;
            m_kind = 0;
            m_pos = 0;
        end else if (ce) begin
            busy = (m_kind != 0);
            s = msel_f();
            // Later writes overwrite earlier ones: B, then A, then restore, then pc_we.
            if (we_b) m_write(wa_b, wd_b, busy, s);
            if (we_a) m_write(wa_a, wd_a, busy, s);
            if (m_kind == 2 && rs_valid) m_r[m_pos] = rs_data;
            if (pc_we) m_pc = pc_wd;
            if (m_kind == 0) begin
                if (ctx_start) begin
                    m_kind = ctx_restore ? 2 : 1;
                    m_pos = 0;
                end
            end else if (m_kind == 3) begin
                m_kind = 0;
            end else if ((m_kind == 1 && sv_ready) || (m_kind == 2 && rs_valid)) begin
                if (m_pos == NSAVE - 1) m_kind = 3;
                else m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        check("pc", 32'(pc), 32'(m_pc));
        check("sp", 32'(sp), 32'(m_sp[msel_f()]));
        check("rd_a", 32'(rd_a), 32'(m_read(rs_a)));
        check("rd_b", 32'(rd_b), 32'(m_read(rs_b)));
        check("ctx_busy", 32'(ctx_busy), 32'(m_kind != 0));
        check("ctx_done", 32'(ctx_done), 32'(m_kind == 3));
        check("sv_valid", 32'(sv_valid), 32'(m_kind == 1));
        check("rs_ready", 32'(rs_ready), 32'(m_kind == 2));
        if (m_kind == 1) begin
            check("sv_idx", 32'(sv_idx), 32'(m_pos));
            check("sv_data", 32'(sv_data), 32'(m_r[m_pos]));
        end
        if (ctx_done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [W-1:0] q [$];
    int d0;
    int k;

    initial begin
        #1 reset_n = 1'b0;
        #21 reset_n = 1'b1;
        #1;
        check("rst_pc", 32'(pc), 32'o100000);
        check("rst_rd_r0", 32'(rd_a), 32'h0);
        check("rst_busy", 32'(ctx_busy), 32'h0);
        check("rst_idx", 32'(sv_idx), 32'h0);
        check("rst_flags", 32'({ctx_done, sv_valid, rs_ready}), 32'h0);
        tick();

        // Port A beats port B on the same register.
        we_a = 1; wa_a = 3; wd_a = 16'h1111;
        we_b = 1; wa_b = 3; wd_b = 16'h2222;
        tick();
        we_a = 0; we_b = 0; rs_a = 3;
        #1 check("a_wins_r3", 32'(rd_a), 32'h1111);
        tick();

        // pc_we beats both ports targeting index 7.
        pc_we = 1; pc_wd = 16'o1000;
        we_a = 1; wa_a = 7; wd_a = 16'h5555;
        we_b = 1; wa_b = 7; wd_b = 16'h6666;
        tick();
        pc_we = 0; we_a = 0; we_b = 0;
        #1 check("pc_we_wins", 32'(pc), 32'o1000);
        tick();

        // Writes are held off while ce is low.
        ce = 0; we_a = 1; wa_a = 4; wd_a = 16'h7777;
        tick();
        we_a = 0; ce = 1; rs_a = 4;
        #1 check("ce_low_r4", 32'(rd_a), 32'h0);
        tick();

        // Banked SP.
        mode = 1; we_a = 1; wa_a = 6; wd_a = 16'o777;
        tick();
        mode = 0; wd_a = 16'o400;
        tick();
        we_a = 0; rs_b = 6;
        #1 check("sp_mode0", 32'(sp), 32'o400);
        check("rd_idx6_mode0", 32'(rd_b), 32'o400);
        mode = 1;
        #1 check("sp_mode1", 32'(sp), 32'o777);
        tick();
        mode = 0;

        // Load R0..R5 = 1..6.
        for (int i = 0; i < 6; i += 2) begin
            we_a = 1; wa_a = 3'(i);     wd_a = 16'(i + 1);
            we_b = 1; wa_b = 3'(i + 1); wd_b = 16'(i + 2);
            tick();
        end
        we_a = 0; we_b = 0;

        // Save with sv_ready toggling; a port write to R1 during the transfer is dropped.
        d0 = done_seen;
        ctx_start = 1; ctx_restore = 0;
        tick();
        ctx_start = 0;
        for (int c = 0; c < 40; c++) begin
            if (!ctx_busy && done_seen != d0) break;
            sv_ready = c[0];
            we_a = 1; wa_a = 1; wd_a = 16'hDEAD;
            #1;
            if (sv_valid && sv_ready) q.push_back(sv_data);
            if (sv_valid && !sv_ready) check("sv_hold", 32'(sv_data), 32'(sv_idx) + 32'd1);
            tick();
        end
        we_a = 0; sv_ready = 0;
        check("save_count", 32'(q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check("save_seq", (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(i + 1));
        check("save_done_pulses", 32'(done_seen - d0), 32'd1);
        rs_a = 1;
        #1 check("r1_write_dropped", 32'(rd_a), 32'h2);
        tick();

        // Restore A0..A5 with stalls and a competing port write to R2.
        d0 = done_seen;
        k = 0;
        ctx_start = 1; ctx_restore = 1;
        tick();
        ctx_start = 0;
        for (int c = 0; c < 40; c++) begin
            if (!ctx_busy && done_seen != d0) break;
            rs_valid = (c % 3 != 1);
            rs_data = 16'hA0 + 16'(k);
            we_a = 1; wa_a = 2; wd_a = 16'hBEEF;
            #1;
            if (rs_ready && rs_valid) k++;
            tick();
        end
        we_a = 0; rs_valid = 0;
        check("restore_done_pulses", 32'(done_seen - d0), 32'd1);
        check("restore_idle", 32'(ctx_busy), 32'h0);
        for (int i = 0; i < 6; i++) begin
            rs_a = 3'(i);
            #1 check("restored_r", 32'(rd_a), 32'hA0 + 32'(i));
            tick();
        end

        // Reset in the middle of a save.
        d0 = done_seen;
        ctx_start = 1; ctx_restore = 0; sv_ready = 1;
        tick();
        ctx_start = 0;
        tick(); tick(); tick();
        reset_n = 0;
        #1 check("abort_busy", 32'(ctx_busy), 32'h0);
        check("abort_flags", 32'({ctx_done, sv_valid}), 32'h0);
        tick(); tick();
        reset_n = 1; sv_ready = 0; rs_a = 0;
        #1 check("abort_r0_cleared", 32'(rd_a), 32'h0);
        ctx_start = 1;
        tick();
        ctx_start = 0;
        #1 check("restart_idx", 32'(sv_idx), 32'h0);
        check("restart_valid", 32'(sv_valid), 32'h1);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        sv_ready = 1;
        for (int c = 0; c < 10; c++) tick();
        sv_ready = 0;
        check("final_idle", 32'(ctx_busy), 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
